// File: rtl/watch_pkg.sv
// Shared watch definitions: FSM states, field limits and HMS display blank codes.
// Used by the set controller and by the display path.
package watch_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [6:0] HOUR_MAX = 7'd23;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] SEC_MAX  = 7'd59;

  localparam logic [1:0] EN_NONE = 2'b00;
  localparam logic [1:0] EN_SEC  = 2'b01;
  localparam logic [1:0] EN_MIN  = 2'b10;
  localparam logic [1:0] EN_HOUR = 2'b11;

  // >= rather than == so an out-of-range value can never propagate
  function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] max);
    return (v >= max) ? 7'd0 : v + 7'd1;
  endfunction

  function automatic logic [1:0] blank_code(input state_t s);
    case (s)
      SET_HOUR: return EN_HOUR;
      SET_MIN:  return EN_MIN;
      SET_SEC:  return EN_SEC;
      default:  return EN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/watch_divider.sv
// Modulo-DIV counter with synchronous clear; wrap is high in the cycle the count sits at DIV-1.
// Wrap is combinational from the count, so its consumer acts at the same edge the count returns to 0.
module watch_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign wrap = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// HMS watch with mode/inc button setting and blinking field blanking; all outputs registered,
// field updates land one edge after the button press is seen.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [6:0] secs,
  output logic [6:0] mins,
  output logic [6:0] hours,
  output logic [1:0] enable
);

  state_t state, state_nx;
  logic   mode_d, inc_d;
  logic   mode_arm, inc_arm;
  logic   mode_press, inc_press;
  logic   phase, phase_nx;
  logic   in_run;
  logic   tick, blink_wrap;

  // A button held across reset must be seen released before it can press
  assign mode_press = btn_mode & ~mode_d & mode_arm;
  assign inc_press  = btn_inc & ~inc_d & inc_arm;
  assign in_run     = (state == RUN);

  watch_divider #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (in_run),
    .clr  (~in_run | mode_press),
    .wrap (tick)
  );

  watch_divider #(.DIV(BLINK_DIV)) u_blink (
    .clk  (clk),
    .rst  (rst),
    .en   (~in_run),
    .clr  (in_run | mode_press),
    .wrap (blink_wrap)
  );

  always_comb begin
    state_nx = state;
    if (mode_press) begin
      case (state)
        RUN:      state_nx = SET_HOUR;
        SET_HOUR: state_nx = SET_MIN;
        SET_MIN:  state_nx = SET_SEC;
        default:  state_nx = RUN;
      endcase
    end
  end

  always_comb begin
    phase_nx = phase;
    if (in_run || mode_press) begin
      phase_nx = 1'b0;
    end else if (blink_wrap) begin
      phase_nx = ~phase;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      phase    <= 1'b0;
      mode_d   <= 1'b0;
      inc_d    <= 1'b0;
      mode_arm <= 1'b0;
      inc_arm  <= 1'b0;
      secs     <= 7'd0;
      mins     <= 7'd0;
      hours    <= 7'd0;
      enable   <= EN_NONE;
    end else begin
      mode_d   <= btn_mode;
      inc_d    <= btn_inc;
      mode_arm <= mode_arm | ~btn_mode;
      inc_arm  <= inc_arm | ~btn_inc;
      state    <= state_nx;
      phase    <= phase_nx;
      enable   <= phase_nx ? blank_code(state_nx) : EN_NONE;

      // tick only exists in RUN and inc only acts in SET states, so these never collide
      if (tick) begin
        secs <= wrap_inc(secs, SEC_MAX);
        if (secs >= SEC_MAX) begin
          mins <= wrap_inc(mins, MIN_MAX);
          if (mins >= MIN_MAX) begin
            hours <= wrap_inc(hours, HOUR_MAX);
          end
        end
      end else if (inc_press && !mode_press) begin
        case (state)
          SET_HOUR: hours <= wrap_inc(hours, HOUR_MAX);
          SET_MIN:  mins  <= wrap_inc(mins, MIN_MAX);
          SET_SEC:  secs  <= wrap_inc(secs, SEC_MAX);
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: doc/watch_set_ctrl.md
WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clock cycles per one-second tick.
REQ-002 SHALL have parameter BLINK_DIV, default 12500000, clock cycles per blink-phase toggle.
REQ-003 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port btn_mode, input, 1, synchronous level, high = mode button pressed.
REQ-006 SHALL have port btn_inc, input, 1, synchronous level, high = increment button pressed.
REQ-007 SHALL have port secs, output, 7, seconds value 0..59.
REQ-008 SHALL have port mins, output, 7, minutes value 0..59.
REQ-009 SHALL have port hours, output, 7, hours value 0..23.
REQ-010 SHALL have port enable, output, 2, blank code for the HMS display: 00 none, 01 seconds, 10 minutes, 11 hours.

Function
REQ-011 SHALL implement FSM states RUN, SET_HOUR, SET_MIN, SET_SEC.
REQ-012 SHALL detect a press as btn high while its one-cycle-delayed copy is low; a held button produces exactly one press.
REQ-013 SHALL advance on a mode press: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN; the state register updates at the edge where the press is detected.
REQ-014 SHALL, in RUN, count a prescaler 0..TICK_DIV-1 and issue one tick when it wraps from TICK_DIV-1 to 0.
REQ-015 SHALL, on tick: secs+1; secs 59->0 carries mins+1; mins 59->0 carries hours+1; hours 23->0; all carries in the same cycle (23:59:59 -> 00:00:00 in one edge).
REQ-016 SHALL hold the prescaler at 0 and generate no ticks in any SET state; the first tick after returning to RUN occurs TICK_DIV cycles after the RUN entry edge.
REQ-017 SHALL, on an inc press in SET_x, increment field x modulo its limit (hours 23->0, mins/secs 59->0) with no carry into other fields; one-cycle latency from the press cycle to the output.
REQ-018 SHALL ignore inc presses in RUN.
REQ-019 SHALL give mode priority when mode and inc presses occur in the same cycle: state advances, no field changes.
REQ-020 SHALL, in SET states, run a blink counter 0..BLINK_DIV-1 toggling a phase bit on each wrap; counter and phase clear to 0 (visible) on every state change.
REQ-021 SHALL drive enable = 00 in RUN and in visible phase; in blank phase enable = 11 / 10 / 01 for SET_HOUR / SET_MIN / SET_SEC.
REQ-022 SHALL register all outputs (no combinational path from buttons to outputs).
REQ-023 SHALL never output a field value above its limit.

Reset
REQ-024 SHALL, while rst is high, force state RUN, secs=mins=hours=0, enable=00, prescaler=0, blink counter=0, phase visible, button delay registers 0.
REQ-025 SHALL, on rst deassertion with a button already high, not register a press until that button goes low and high again.
REQ-026 SHALL abandon any set operation on reset mid-operation; no partial increment survives.

Structure
REQ-027 SHALL place state encodings, field limits (23, 59) and the enable codes (00/01/10/11) in shared package watch_pkg, reused by the display path.
REQ-028 SHALL use one sub-module watch_divider (parameterised modulo counter with clear input and wrap pulse), instantiated for the tick prescaler and the blink counter.
REQ-029 SHALL compute no division or modulo at runtime; wraps are compare-to-limit.

Verification (TICK_DIV=4, BLINK_DIV=3)
REQ-030 SHALL cover: reset, 4*60 cycles in RUN -> secs=0, mins=1, hours=0, enable=00 throughout.
REQ-031 SHALL cover: preload 23:59:59 via SET mode, return to RUN, 4 cycles -> 00:00:00 on a single edge.
REQ-032 SHALL cover: mode press once -> SET_HOUR; enable 00 for 3 cycles, 11 for 3 cycles, repeating; time frozen.
REQ-033 SHALL cover: SET_HOUR at 23, btn_inc held 10 cycles -> hours=0 exactly one cycle after press, no further change, mins unchanged.
REQ-034 SHALL cover: mode and inc rise in the same cycle in SET_MIN -> state SET_SEC, mins unchanged, enable restarts at 00.
REQ-035 SHALL cover: rst asserted mid SET_SEC with btn_mode held through deassertion -> all outputs 0 and state RUN immediately; no state advance until btn_mode toggles.
